rxe_preamble_strip: RTL and testbench

Parametrised Ethernet receive preamble/SFD stripper for the byte-wide RX path, sitting between the PHY-side byte assembler and the CRC checker/packet buffer. Validates a minimum-length preamble and a configurable start-frame delimiter, then forwards only the payload bytes with a one-byte look-ahead so the final byte is marked `o_last`. Frames with a malformed or short preamble are discarded whole, flagged with a one-cycle `o_err` pulse, and counted in a saturating drop counter. A bypass mode passes the raw stream through unchanged.

---
 rtl/rxe_preamble_strip.sv | 153 +++++++++++++++
 tb/tb_rxe_preamble_strip.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rxe_preamble_strip.sv
// Ethernet RX preamble/SFD stripper: checks the preamble, drops bad frames
// and forwards payload with one byte of look-ahead to mark the last byte.
module rxe_preamble_strip #(
    parameter int          MIN_SYNCS = 7,
    parameter logic [7:0]  SYNC_BYTE = 8'h55,
    parameter logic [7:0]  SFD_BYTE  = 8'hd5,
    parameter int          CNTW      = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ce,
    input  logic            i_en,
    input  logic            i_v,
    input  logic [7:0]      i_d,
    output logic            o_v,
    output logic [7:0]      o_d,
    output logic            o_last,
    output logic            o_err,
    output logic [CNTW-1:0] o_drops
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DISCARD
    } state_t;

    localparam logic [3:0] MIN_N = 4'(MIN_SYNCS);

    state_t            state_q, state_d;
    logic [3:0]        nsyncs_q, nsyncs_d;
    logic              h_v_q, h_v_d;
    logic [7:0]        h_d_q, h_d_d;
    logic              o_v_q, o_v_d;
    logic [7:0]        o_d_q, o_d_d;
    logic              o_last_q, o_last_d;
    logic              o_err_q, o_err_d;
    logic [CNTW-1:0]   drops_q, drops_d;
    logic              drop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            nsyncs_q <= '0;
            h_v_q    <= 1'b0;
            h_d_q    <= '0;
            o_v_q    <= 1'b0;
            o_d_q    <= '0;
            o_last_q <= 1'b0;
            o_err_q  <= 1'b0;
            drops_q  <= '0;
        end else begin
            state_q  <= state_d;
            nsyncs_q <= nsyncs_d;
            h_v_q    <= h_v_d;
            h_d_q    <= h_d_d;
            o_v_q    <= o_v_d;
            o_d_q    <= o_d_d;
            o_last_q <= o_last_d;
            o_err_q  <= o_err_d;
            drops_q  <= drops_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nsyncs_d = nsyncs_q;
        h_v_d    = h_v_q;
        h_d_d    = h_d_q;
        o_v_d    = o_v_q;
        o_d_d    = o_d_q;
        o_last_d = o_last_q;
        o_err_d  = o_err_q;
        drops_d  = drops_q;
        drop     = 1'b0;

        // Outputs are single-strobe registered values; refresh only on i_ce.
        if (i_ce) begin
            o_v_d    = 1'b0;
            o_d_d    = '0;
            o_last_d = 1'b0;
            o_err_d  = 1'b0;

            if (!i_en) begin
                state_d = IDLE;
                o_v_d   = i_v;
                o_d_d   = i_v ? i_d : 8'h00;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (i_v) begin
                            if (i_d == SYNC_BYTE) begin
                                state_d  = PREAMBLE;
                                nsyncs_d = 4'd1;
                            end else begin
                                state_d = DISCARD;
                                drop    = 1'b1;
                            end
                        end
                    end
                    PREAMBLE: begin
                        if (!i_v) begin
                            state_d = IDLE;
                            drop    = 1'b1;
                        end else if (i_d == SYNC_BYTE) begin
                            if (nsyncs_q < MIN_N)
                                nsyncs_d = nsyncs_q + 4'd1;
                        end else if (i_d == SFD_BYTE && nsyncs_q >= MIN_N) begin
                            state_d = PAYLOAD;
                            h_v_d   = 1'b0;
                        end else begin
                            state_d = DISCARD;
                            drop    = 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        o_v_d = h_v_q;
                        o_d_d = h_v_q ? h_d_q : 8'h00;
                        if (i_v) begin
                            h_d_d = i_d;
                            h_v_d = 1'b1;
                        end else begin
                            // Flush the held byte as the frame's last.
                            o_last_d = h_v_q;
                            h_v_d    = 1'b0;
                            state_d  = IDLE;
                        end
                    end
                    DISCARD: begin
                        if (!i_v)
                            state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase

                if (drop) begin
                    o_err_d  = 1'b1;
                    nsyncs_d = '0;
                    if (drops_q != '1)
                        drops_d = drops_q + CNTW'(1);
                end
            end
        end
    end

    assign o_v     = o_v_q;
    assign o_d     = o_d_q;
    assign o_last  = o_last_q;
    assign o_err   = o_err_q;
    assign o_drops = drops_q;

endmodule

// File: tb/tb_rxe_preamble_strip.sv
// Directed-vector bench for rxe_preamble_strip.
module tb_rxe_preamble_strip;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_ce = 1'b1;
    logic        i_en = 1'b1;
    logic        i_v = 1'b0;
    logic [7:0]  i_d = 8'h00;

    logic        o_v, o_last, o_err;
    logic [7:0]  o_d;
    logic [15:0] o_drops;

    logic        d2_v, d2_last, d2_err;
    logic [7:0]  d2_d;
    logic [1:0]  d2_drops;

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    rxe_preamble_strip dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_en(i_en),
        .i_v(i_v), .i_d(i_d), .o_v(o_v), .o_d(o_d), .o_last(o_last),
        .o_err(o_err), .o_drops(o_drops)
    );

    rxe_preamble_strip #(.CNTW(2)) dut2 (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_en(i_en),
        .i_v(i_v), .i_d(i_d), .o_v(d2_v), .o_d(d2_d), .o_last(d2_last),
        .o_err(d2_err), .o_drops(d2_drops)
    );

    typedef struct {
        logic       en;
        logic       v;
        logic [7:0] d;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic       ee;
        int         edr;
    } vec_t;

    vec_t vq[$];
    logic [7:0] sq[$];
    logic       lq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic v, input logic [7:0] d,
                       input logic ev, input logic [7:0] ed, input logic el,
                       input logic ee, input int edr);
        vec_t r;
        r.en = en; r.v = v; r.d = d;
        r.ev = ev; r.ed = ed; r.el = el; r.ee = ee; r.edr = edr;
        vq.push_back(r);
    endtask

    task automatic addn(input int n, input logic [7:0] d, input int edr);
        for (int i = 0; i < n; i++) add(1, 1, d, 0, 8'h00, 0, 0, edr);
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        i_ce = 1'b1; i_v = v; i_d = d;
        @(posedge i_clk); #1;
    endtask

    task automatic ce_step(input logic v, input logic [7:0] d);
        logic       ov, ol;
        logic [7:0] od;
        ov = 0; ol = 0; od = 0;
        for (int k = 0; k < 10; k++) begin
            i_ce = (k == 0); i_v = v; i_d = d;
            @(posedge i_clk); #1;
            if (k == 0) begin
                ov = o_v; ol = o_last; od = o_d;
                if (o_v) begin
                    sq.push_back(o_d);
                    lq.push_back(o_last);
                end
            end else begin
                chk("hold_between_strobes", {22'd0, o_v, o_last, o_d},
                    {22'd0, ov, ol, od});
            end
        end
    endtask

    initial begin
        int rexp[5];
        logic [7:0] bexp[4];
        rexp = '{1, 2, 3, 3, 3};
        bexp = '{8'hb1, 8'hb2, 8'hb3, 8'hb4};

        // Good frame: 01 02 03
        addn(7, 8'h55, 0);
        add(1, 1, 8'hd5, 0, 8'h00, 0, 0, 0);
        add(1, 1, 8'h01, 0, 8'h00, 0, 0, 0);
        add(1, 1, 8'h02, 1, 8'h01, 0, 0, 0);
        add(1, 1, 8'h03, 1, 8'h02, 0, 0, 0);
        add(1, 0, 8'h00, 1, 8'h03, 1, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        // Too few syncs before SFD
        addn(6, 8'h55, 0);
        add(1, 1, 8'hd5, 0, 8'h00, 0, 1, 1);
        add(1, 1, 8'haa, 0, 8'h00, 0, 0, 1);
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 1);
        // Bad byte inside a long preamble, then a good frame after one gap
        addn(8, 8'h55, 1);
        add(1, 1, 8'h54, 0, 8'h00, 0, 1, 2);
        add(1, 1, 8'h55, 0, 8'h00, 0, 0, 2);
        add(1, 1, 8'hd5, 0, 8'h00, 0, 0, 2);
        add(1, 1, 8'h11, 0, 8'h00, 0, 0, 2);
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 2);
        addn(7, 8'h55, 2);
        add(1, 1, 8'hd5, 0, 8'h00, 0, 0, 2);
        add(1, 1, 8'ha1, 0, 8'h00, 0, 0, 2);
        add(1, 1, 8'ha2, 1, 8'ha1, 0, 0, 2);
        add(1, 0, 8'h00, 1, 8'ha2, 1, 0, 2);
        // Zero-length payload
        addn(7, 8'h55, 2);
        add(1, 1, 8'hd5, 0, 8'h00, 0, 0, 2);
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 2);
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 2);
        // Bypass
        add(0, 0, 8'h00, 0, 8'h00, 0, 0, 2);
        add(0, 1, 8'h55, 1, 8'h55, 0, 0, 2);
        add(0, 1, 8'hd5, 1, 8'hd5, 0, 0, 2);
        add(0, 1, 8'h7e, 1, 8'h7e, 0, 0, 2);
        add(0, 0, 8'h00, 0, 8'h00, 0, 0, 2);
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 2);

        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        chk("rst_o_v", o_v, 0);
        chk("rst_o_d", o_d, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_o_err", o_err, 0);
        chk("rst_o_drops", o_drops, 0);

        foreach (vq[i]) begin
            i_en = vq[i].en;
            step(vq[i].v, vq[i].d);
            chk($sformatf("vec%0d_o_v", i), o_v, vq[i].ev);
            chk($sformatf("vec%0d_o_d", i), o_d, vq[i].ed);
            chk($sformatf("vec%0d_o_last", i), o_last, vq[i].el);
            chk($sformatf("vec%0d_o_err", i), o_err, vq[i].ee);
            chk($sformatf("vec%0d_o_drops", i), o_drops, vq[i].edr);
        end

        // Sparse strobe: 1 in 10 cycles
        i_en = 1'b1;
        for (int i = 0; i < 7; i++) ce_step(1, 8'h55);
        ce_step(1, 8'hd5);
        for (int i = 0; i < 4; i++) ce_step(1, bexp[i]);
        ce_step(0, 8'h00);
        ce_step(0, 8'h00);
        chk("strobe_count", sq.size(), 4);
        for (int i = 0; i < 4 && i < sq.size(); i++) begin
            chk($sformatf("strobe_byte%0d", i), sq[i], bexp[i]);
            chk($sformatf("strobe_last%0d", i), lq[i], (i == 3));
        end

        // Narrow saturating counter with runts
        i_ce = 1'b1; i_v = 1'b0; i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        chk("rst2_drops", d2_drops, 0);
        for (int r = 0; r < 5; r++) begin
            repeat (3) step(1, 8'h55);
            step(0, 8'h00);
            chk($sformatf("runt%0d_drops", r), d2_drops, rexp[r]);
            chk($sformatf("runt%0d_err", r), d2_err, 1);
        end
        step(0, 8'h00);
        chk("runt_err_clear", d2_err, 0);

        // Reset mid-payload
        repeat (7) step(1, 8'h55);
        step(1, 8'hd5);
        step(1, 8'hc1);
        step(1, 8'hc2);
        chk("mid_o_v", o_v, 1);
        chk("mid_o_d", o_d, 8'hc1);
        i_reset = 1'b1;
        step(1, 8'hc3);
        i_reset = 1'b0;
        chk("mrst_o_v", o_v, 0);
        chk("mrst_o_drops", o_drops, 0);
        chk("mrst_d2_drops", d2_drops, 0);
        step(1, 8'hc4);
        chk("tail_err", o_err, 1);
        chk("tail_drops", o_drops, 1);
        step(1, 8'hc5);
        chk("tail2_err", o_err, 0);
        chk("tail2_v", o_v, 0);
        step(0, 8'h00);
        chk("tail3_drops", o_drops, 1);
        chk("tail3_v", o_v, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
